// File: rtl/membrane_key_emulator.sv
// ============================================================================
// membrane_key_emulator
// ----------------------------------------------------------------------------
// Keypad-side model of a 3x4 membrane matrix. A key code is accepted over a
// valid/ready handshake. The emulator watches the scanner's three row drives.
// It then returns the matching column line for HOLD_SCANS scan frames,
// followed by GAP_SCANS frames of full release.
//
// Frame boundary: falling edge of row2 (registered row2 high, live row2 low).
//
// Optional feature (compile-time macro): KEY_BOUNCE_EN
//   When defined, the first BOUNCE_SCANS frames of a press assert the column
//   only on odd-numbered frames (1st, 3rd, ...). This models contact chatter.
//
// Ports:
//   clk                 system clock (only clock)
//   rst                 asynchronous, active-high reset
//   row0, row1, row2    scanner row drives, synchronous to clk
//   in_key[3:0]         key code to press (0-9 digits, 10 hash, 11 star)
//   in_valid            in_key is valid
//   in_ready            idle; key accepted on in_valid & in_ready
//   col0..col3          column returns to the scanner (combinational)
//   busy                high from acceptance until return to idle
//   done                one-cycle pulse when the release gap completes
// ============================================================================
module membrane_key_emulator #(
   parameter int HOLD_SCANS   = 3,
   parameter int GAP_SCANS    = 2,
   parameter int BOUNCE_SCANS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       row0,
   input  logic       row1,
   input  logic       row2,
   input  logic [3:0] in_key,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       col0,
   output logic       col1,
   output logic       col2,
   output logic       col3,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_PRESS, S_GAP} state_t;

   // A frame count of zero would never terminate, so it is treated as one.
   localparam logic [7:0] HOLD_LD    = (HOLD_SCANS <= 0) ? 8'd1 : 8'(HOLD_SCANS);
   localparam logic [7:0] GAP_LD     = (GAP_SCANS  <= 0) ? 8'd1 : 8'(GAP_SCANS);
   localparam logic [7:0] BOUNCE_LEN = 8'(BOUNCE_SCANS);
`ifdef KEY_BOUNCE_EN
   localparam logic BOUNCE_ON = 1'b1;
`else
   localparam logic BOUNCE_ON = 1'b0;
`endif

   state_t     state_q, state_d;
   logic [3:0] key_q,   key_d;
   logic [7:0] cnt_q,   cnt_d;
   logic       ready_q, ready_d;
   logic       busy_q,  busy_d;
   logic       done_q,  done_d;
   logic       row2_q;

   logic       boundary;
   logic       accept;
   logic [1:0] key_row;
   logic [3:0] key_cols;
   logic       row_hit;
   logic [7:0] press_idx;
   logic       bounce_off;
   logic [3:0] col_vec;

   assign boundary = row2_q & ~row2;
   assign accept   = in_valid & ready_q & (state_q == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         key_q   <= 4'd13;
         cnt_q   <= 8'd0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         row2_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         row2_q  <= row2;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               key_d   = in_key;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (boundary) begin
               cnt_d   = HOLD_LD;
               state_d = S_PRESS;
            end
         end
         S_PRESS: begin
            // The transition test uses "<= 1" so the counter can never wrap.
            if (boundary) begin
               if (cnt_q <= 8'd1) begin
                  cnt_d   = GAP_LD;
                  state_d = S_GAP;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         S_GAP: begin
            if (boundary) begin
               if (cnt_q <= 8'd1) begin
                  cnt_d   = 8'd0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Ready is held low through reset and rises on the first clock after it.
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   // Key map: row index plus a one-hot column. Codes 12-15 map to no column.
   always_comb begin
      key_row  = 2'd3;
      key_cols = 4'b0000;
      case (key_q)
         4'd1:  begin key_row = 2'd0; key_cols = 4'b0001; end
         4'd4:  begin key_row = 2'd0; key_cols = 4'b0010; end
         4'd7:  begin key_row = 2'd0; key_cols = 4'b0100; end
         4'd11: begin key_row = 2'd0; key_cols = 4'b1000; end
         4'd2:  begin key_row = 2'd1; key_cols = 4'b0001; end
         4'd5:  begin key_row = 2'd1; key_cols = 4'b0010; end
         4'd8:  begin key_row = 2'd1; key_cols = 4'b0100; end
         4'd0:  begin key_row = 2'd1; key_cols = 4'b1000; end
         4'd3:  begin key_row = 2'd2; key_cols = 4'b0001; end
         4'd6:  begin key_row = 2'd2; key_cols = 4'b0010; end
         4'd9:  begin key_row = 2'd2; key_cols = 4'b0100; end
         4'd10: begin key_row = 2'd2; key_cols = 4'b1000; end
         default: begin key_row = 2'd3; key_cols = 4'b0000; end
      endcase
   end

   // Only the key's own row matters; other rows are ignored.
   always_comb begin
      case (key_row)
         2'd0:    row_hit = row0;
         2'd1:    row_hit = row1;
         2'd2:    row_hit = row2;
         default: row_hit = 1'b0;
      endcase
   end

   // Zero-based frame index within PRESS. Odd indices are the 2nd, 4th, ...
   // frames, which are released during the chatter window.
   assign press_idx  = HOLD_LD - cnt_q;
   assign bounce_off = BOUNCE_ON & (press_idx < BOUNCE_LEN) & press_idx[0];

   // Combinational so the scanner sees the column in the same cycle as its row.
   assign col_vec = ((state_q == S_PRESS) && row_hit && !bounce_off) ? key_cols : 4'b0000;

   assign col0     = col_vec[0];
   assign col1     = col_vec[1];
   assign col2     = col_vec[2];
   assign col3     = col_vec[3];
   assign in_ready = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_membrane_key_emulator.sv
// Directed bench for membrane_key_emulator. A simple 12-cycle scanner frame
// drives row0 (cycles 0-1), row1 (4-5) and row2 (8-9). The columns seen
// under each row are collected per frame and compared with hand-derived
// expectations.
module tb_membrane_key_emulator;

`ifdef KEY_BOUNCE_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 3;
`endif
   localparam int GAP    = 2;
   localparam int BOUNCE = 2;
   localparam int NFRM   = 1 + HOLD + GAP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       row0 = 1'b0, row1 = 1'b0, row2 = 1'b0;
   logic [3:0] in_key = 4'd0;
   logic       in_valid = 1'b0;
   logic       in_ready, col0, col1, col2, col3, busy, done;

   int checks = 0;
   int errors = 0;

   membrane_key_emulator #(
      .HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .BOUNCE_SCANS(BOUNCE)
   ) dut (
      .clk(clk), .rst(rst), .row0(row0), .row1(row1), .row2(row2),
      .in_key(in_key), .in_valid(in_valid), .in_ready(in_ready),
      .col0(col0), .col1(col1), .col2(col2), .col3(col3),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] cols();
      return {col3, col2, col1, col0};
   endfunction

   // Expected press state of zero-based PRESS frame i.
   function automatic bit frame_on(input int i);
`ifdef KEY_BOUNCE_EN
      return !((i < BOUNCE) && (i % 2 == 1));
`else
      return (i >= 0);
`endif
   endfunction

   // One scanner frame; collects columns seen under each row and with no row.
   task automatic run_frame(output logic [3:0] rc0, output logic [3:0] rc1,
                            output logic [3:0] rc2, output logic [3:0] rlow,
                            output int dn, output int rdy);
      rc0 = 0; rc1 = 0; rc2 = 0; rlow = 0; dn = 0; rdy = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(posedge clk); #1;
         row0 = (cyc < 2);
         row1 = (cyc >= 4 && cyc < 6);
         row2 = (cyc >= 8 && cyc < 10);
         @(negedge clk);
         if (row0)      rc0  |= cols();
         else if (row1) rc1  |= cols();
         else if (row2) rc2  |= cols();
         else           rlow |= cols();
         dn  += int'(done);
         rdy += int'(in_ready);
      end
   endtask

   // Called at a negedge; returns at a negedge one cycle after acceptance.
   task automatic accept(input logic [3:0] k, input bit keep, input logic [3:0] nk);
      int n = 0;
      in_key   = k;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 200), 32'd1);
      @(posedge clk); #1;
      if (keep) in_key = nk;
      else      in_valid = 1'b0;
      @(negedge clk);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("ready_after_accept", 32'(in_ready), 32'd0);
   endtask

   task automatic key_seq(input string nm, input logic [3:0] k, input int er,
                          input logic [3:0] ec, input bit keep, input logic [3:0] nk);
      logic [3:0] rc[3];
      logic [3:0] rlow, ex;
      int dn, rdy;
      accept(k, keep, nk);
      for (int f = 0; f < NFRM; f++) begin
         run_frame(rc[0], rc[1], rc[2], rlow, dn, rdy);
         for (int r = 0; r < 3; r++) begin
            ex = (f >= 1 && f <= HOLD && r == er && frame_on(f - 1)) ? ec : 4'b0000;
            chk($sformatf("%s_f%0d_row%0d_cols", nm, f, r), 32'(rc[r]), 32'(ex));
         end
         chk($sformatf("%s_f%0d_norow_cols", nm, f), 32'(rlow), 32'd0);
         chk($sformatf("%s_f%0d_done", nm, f), 32'(dn), 32'(f == NFRM - 1));
         chk($sformatf("%s_f%0d_ready", nm, f), 32'(rdy), 32'(f == NFRM - 1));
      end
      chk($sformatf("%s_end_busy", nm), 32'(busy), 32'd0);
      $display("key %0d (%s) sequence complete, checks %0d", k, nm, checks);
   endtask

   initial begin
      logic [3:0] a0, a1, a2, al;
      int dn, rdy;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_busy",  32'(busy),     32'd0);
      chk("rst_done",  32'(done),     32'd0);
      chk("rst_cols",  32'(cols()),   32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      key_seq("k5", 4'd5, 1, 4'b0010, 1'b0, 4'd0);
      // in_valid held across two keys; the second code must not be taken early
      key_seq("k11", 4'd11, 0, 4'b1000, 1'b1, 4'd10);
      key_seq("k10", 4'd10, 2, 4'b1000, 1'b0, 4'd0);
      key_seq("k7a", 4'd7, 0, 4'b0100, 1'b0, 4'd0);
      key_seq("k7b", 4'd7, 0, 4'b0100, 1'b0, 4'd0);
      key_seq("k13", 4'd13, 3, 4'b0000, 1'b0, 4'd0);
      key_seq("k14", 4'd14, 3, 4'b0000, 1'b0, 4'd0);

      // Reset in the middle of PRESS on key 3 (row2, col0)
      accept(4'd3, 1'b0, 4'd0);
      run_frame(a0, a1, a2, al, dn, rdy);
      @(posedge clk); #1;
      row2 = 1'b1;
      @(negedge clk);
      chk("k3_press_col0", 32'(cols()), 32'b0001);
      #1 rst = 1'b1;
      #1;
      chk("k3_rst_cols_async", 32'(cols()), 32'd0);
      chk("k3_rst_busy", 32'(busy), 32'd0);
      chk("k3_rst_ready", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst  = 1'b0;
      row2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("k3_post_rst_ready", 32'(in_ready), 32'd1);
      chk("k3_post_rst_busy", 32'(busy), 32'd0);
      key_seq("k9", 4'd9, 2, 4'b0100, 1'b0, 4'd0);

`ifdef KEY_BOUNCE_EN
      key_seq("k8_bounce", 4'd8, 1, 4'b0100, 1'b0, 4'd0);
`else
      key_seq("k8", 4'd8, 1, 4'b0100, 1'b0, 4'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
